// File: rtl/ps2_pkg.sv
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared types and constants for the PS/2 keyboard receiver.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } rx_state_t;

   localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
   localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;

   // keyb_char layout: {pad, ext, code}
   localparam int KEYB_CHAR_W = 32;
   localparam int KEYB_CODE_W = 8;
   localparam int KEYB_KEY_W  = KEYB_CODE_W + 1;
   localparam int KEYB_PAD_W  = KEYB_CHAR_W - KEYB_KEY_W;

endpackage

`default_nettype wire

// File: rtl/ps2_rx_frame.sv
// ============================================================================
// Module   : ps2_rx_frame
// Brief    : PS/2 pin conditioning and 11-bit frame deframer with timeout.
//            Parity enforcement is enabled by defining PS2_PARITY_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ps2_clk,
   input  logic                   ps2_data,
   output logic [KEYB_CODE_W-1:0] rx_byte,
   output logic                   rx_valid,
   output logic                   rx_err
);

   localparam int FCNT_W = $clog2(FILTER_LEN + 1);
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]             clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
   logic                   clk_filt_q, clk_filt_d, data_filt_q, data_filt_d;
   logic                   clk_prev_q, clk_prev_d;
   logic [FCNT_W-1:0]      clk_cnt_q, clk_cnt_d, data_cnt_q, data_cnt_d;
   rx_state_t              state_q, state_d;
   logic [2:0]             bitcnt_q, bitcnt_d;
   logic [KEYB_CODE_W-1:0] shift_q, shift_d, rx_byte_q, rx_byte_d;
   logic                   par_q, par_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic                   rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;
   logic                   fall, parity_ok;

`ifdef PS2_PARITY_CHECK_EN
   assign parity_ok = ^{shift_q, par_q};
`else
   assign parity_ok = 1'b1;
`endif

   assign fall = clk_prev_q & ~clk_filt_q;

   // Filtered level flips only after FILTER_LEN consecutive differing samples
   always_comb begin
      clk_sync_d  = {clk_sync_q[0], ps2_clk};
      data_sync_d = {data_sync_q[0], ps2_data};
      clk_prev_d  = clk_filt_q;
      clk_filt_d  = clk_filt_q;
      data_filt_d = data_filt_q;
      clk_cnt_d   = '0;
      data_cnt_d  = '0;
      if (clk_sync_q[1] != clk_filt_q) begin
         if (clk_cnt_q == FCNT_LAST) clk_filt_d = clk_sync_q[1];
         else                        clk_cnt_d  = clk_cnt_q + 1'b1;
      end
      if (data_sync_q[1] != data_filt_q) begin
         if (data_cnt_q == FCNT_LAST) data_filt_d = data_sync_q[1];
         else                         data_cnt_d  = data_cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      bitcnt_d   = bitcnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      rx_byte_d  = rx_byte_q;
      rx_valid_d = 1'b0;
      rx_err_d   = 1'b0;
      tmo_d      = (state_q == IDLE || fall) ? '0 : tmo_q + 1'b1;
      if (state_q != IDLE && !fall && tmo_q == TMO_LAST) begin
         state_d  = IDLE;
         rx_err_d = 1'b1;
         tmo_d    = '0;
      end else if (fall) begin
         case (state_q)
            IDLE: begin
               if (!data_filt_q) begin
                  state_d  = DATA;
                  bitcnt_d = 3'd0;
               end
            end
            DATA: begin
               shift_d[bitcnt_q] = data_filt_q;
               if (bitcnt_q == 3'd7) state_d  = PARITY;
               else                  bitcnt_d = bitcnt_q + 3'd1;
            end
            PARITY: begin
               par_d   = data_filt_q;
               state_d = STOP;
            end
            default: begin
               state_d = IDLE;
               if (data_filt_q && parity_ok) begin
                  rx_byte_d  = shift_q;
                  rx_valid_d = 1'b1;
               end else begin
                  rx_err_d = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         clk_filt_q  <= 1'b1;
         data_filt_q <= 1'b1;
         clk_prev_q  <= 1'b1;
         clk_cnt_q   <= '0;
         data_cnt_q  <= '0;
         state_q     <= IDLE;
         bitcnt_q    <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         tmo_q       <= '0;
         rx_byte_q   <= '0;
         rx_valid_q  <= 1'b0;
         rx_err_q    <= 1'b0;
      end else begin
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
         clk_filt_q  <= clk_filt_d;
         data_filt_q <= data_filt_d;
         clk_prev_q  <= clk_prev_d;
         clk_cnt_q   <= clk_cnt_d;
         data_cnt_q  <= data_cnt_d;
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         tmo_q       <= tmo_d;
         rx_byte_q   <= rx_byte_d;
         rx_valid_q  <= rx_valid_d;
         rx_err_q    <= rx_err_d;
      end
   end

   assign rx_byte  = rx_byte_q;
   assign rx_valid = rx_valid_q;
   assign rx_err   = rx_err_q;

endmodule

`default_nettype wire

// File: rtl/ps2_keyboard.sv
// ============================================================================
// Module   : ps2_keyboard
// Brief    : PS/2 keyboard receiver with E0/F0 scancode tracking; keyb_char
//            holds the currently pressed key. Optional macro: PS2_PARITY_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_keyboard
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ps2_clk,
   input  logic                   ps2_data,
   output logic [KEYB_CHAR_W-1:0] keyb_char,
   output logic [KEYB_CODE_W-1:0] rx_byte,
   output logic                   rx_valid,
   output logic                   rx_err
);

   logic                  ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
   logic [KEYB_KEY_W-1:0] key_q, key_d;

   ps2_rx_frame #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_frame (
      .clk      (clk),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .rx_err   (rx_err)
   );

   // Break only clears the held key if it names that exact key
   always_comb begin
      ext_pend_d = ext_pend_q;
      brk_pend_d = brk_pend_q;
      key_d      = key_q;
      if (rx_valid) begin
         if (rx_byte == PS2_EXT_CODE) begin
            ext_pend_d = 1'b1;
         end else if (rx_byte == PS2_BREAK_CODE) begin
            brk_pend_d = 1'b1;
         end else if (brk_pend_q) begin
            if ({ext_pend_q, rx_byte} == key_q) key_d = '0;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
         end else begin
            key_d      = {ext_pend_q, rx_byte};
            ext_pend_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ext_pend_q <= 1'b0;
         brk_pend_q <= 1'b0;
         key_q      <= '0;
      end else begin
         ext_pend_q <= ext_pend_d;
         brk_pend_q <= brk_pend_d;
         key_q      <= key_d;
      end
   end

   assign keyb_char = {{KEYB_PAD_W{1'b0}}, key_q};

endmodule

`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
// ============================================================================
// Module   : tb_ps2_keyboard
// Brief    : Self-checking bench for ps2_keyboard (scoreboarded frame events).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ps2_keyboard;

   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT    = 1000;
   localparam int HALF       = 40;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PARITY_ON = 1'b1;
`else
   localparam bit PARITY_ON = 1'b0;
`endif

   typedef struct {
      bit         is_err;
      logic [7:0] b;
   } ev_t;

   typedef struct {
      logic [7:0]  b;
      bit          bad;
      logic [31:0] kc;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        ps2_clk;
   logic        ps2_data;
   logic [31:0] keyb_char;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic        rx_err;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   ev_cnt   = 0;
   int   err_cyc  = 0;
   int   last_fall = 0;
   ev_t  exp_q[$];
   ev_t  mon_ev;
   vec_t vecs[16];
   logic [7:0] last_good;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ps2_keyboard #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .keyb_char (keyb_char),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .rx_err    (rx_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && (rx_valid || rx_err)) begin
         ev_cnt++;
         if (rx_err) err_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got valid=%b err=%b byte=%h, required none",
                     rx_valid, rx_err, rx_byte);
         end else begin
            mon_ev = exp_q.pop_front();
            check("rx_event", {22'd0, rx_err, rx_valid, (rx_valid ? rx_byte : 8'h00)},
                  {22'd0, mon_ev.is_err, ~mon_ev.is_err, (mon_ev.is_err ? 8'h00 : mon_ev.b)});
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      cycles(HALF);
      ps2_clk   = 1'b0;
      last_fall = cyc;
      cycles(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad);
      ev_t  e;
      logic p;
      e.is_err = bad && PARITY_ON;
      e.b      = b;
      exp_q.push_back(e);
      if (!e.is_err) last_good = b;
      p = ~(^b) ^ bad;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(p);
      send_bit(1'b1);
      ps2_data = 1'b1;
      cycles(HALF);
      check("event_seen", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int ev0;
      int delta;
      reset     = 1'b1;
      ps2_clk   = 1'b1;
      ps2_data  = 1'b1;
      last_good = 8'h00;

      vecs[0]  = '{8'h1C, 1'b0, 32'h0000001C};
      vecs[1]  = '{8'hF0, 1'b0, 32'h0000001C};
      vecs[2]  = '{8'h1C, 1'b0, 32'h00000000};
      vecs[3]  = '{8'hE0, 1'b0, 32'h00000000};
      vecs[4]  = '{8'h75, 1'b0, 32'h00000175};
      vecs[5]  = '{8'hE0, 1'b0, 32'h00000175};
      vecs[6]  = '{8'hF0, 1'b0, 32'h00000175};
      vecs[7]  = '{8'h75, 1'b0, 32'h00000000};
      vecs[8]  = '{8'h32, 1'b0, 32'h00000032};
      vecs[9]  = '{8'h1C, 1'b1, (PARITY_ON ? 32'h00000032 : 32'h0000001C)};
      vecs[10] = '{8'h1C, 1'b0, 32'h0000001C};
      vecs[11] = '{8'h32, 1'b0, 32'h00000032};
      vecs[12] = '{8'hF0, 1'b0, 32'h00000032};
      vecs[13] = '{8'h1C, 1'b0, 32'h00000032};
      vecs[14] = '{8'hF0, 1'b0, 32'h00000032};
      vecs[15] = '{8'h32, 1'b0, 32'h00000000};

      cycles(5);
      check("reset_keyb_char", keyb_char, 32'd0);
      check("reset_rx_byte", {24'd0, rx_byte}, 32'd0);
      check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("reset_rx_err", {31'd0, rx_err}, 32'd0);
      reset = 1'b0;
      cycles(20);

      for (int i = 0; i < 16; i++) begin
         send_frame(vecs[i].b, vecs[i].bad);
         check($sformatf("keyb_char_vec%0d", i), keyb_char, vecs[i].kc);
         check($sformatf("rx_byte_vec%0d", i), {24'd0, rx_byte}, {24'd0, last_good});
      end

      // Timeout: start bit plus four data bits, then the clock stops high
      exp_q.push_back('{1'b1, 8'h00});
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      for (int n = 0; n < TIMEOUT + 200 && exp_q.size() != 0; n++) cycles(1);
      check("timeout_event_seen", 32'(exp_q.size()), 32'd0);
      delta = err_cyc - last_fall;
      checks++;
      if (delta < TIMEOUT || delta > TIMEOUT + FILTER_LEN + 10) begin
         failures++;
         $display("FAIL timeout_latency: got %0d cycles, required %0d..%0d",
                  delta, TIMEOUT, TIMEOUT + FILTER_LEN + 10);
      end
      check("timeout_keeps_byte", {24'd0, rx_byte}, {24'd0, last_good});
      send_frame(8'h29, 1'b0);
      check("after_timeout_kc", keyb_char, 32'h00000029);

      // Short clock glitches with data low must not start a frame
      ev0 = ev_cnt;
      ps2_data = 1'b0;
      for (int g = 0; g < 5; g++) begin
         ps2_clk = 1'b0;
         cycles(3);
         ps2_clk = 1'b1;
         cycles(20);
      end
      ps2_data = 1'b1;
      cycles(TIMEOUT + 50);
      check("glitch_no_event", 32'(ev_cnt), 32'(ev0));
      send_frame(8'h1C, 1'b0);
      check("after_glitch_kc", keyb_char, 32'h0000001C);

      // Reset in the middle of a frame
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      reset = 1'b1;
      cycles(3);
      check("midreset_keyb_char", keyb_char, 32'd0);
      check("midreset_rx_byte", {24'd0, rx_byte}, 32'd0);
      check("midreset_flags", {30'd0, rx_valid, rx_err}, 32'd0);
      ps2_data  = 1'b1;
      last_good = 8'h00;
      ev0       = ev_cnt;
      cycles(2);
      reset = 1'b0;
      cycles(TIMEOUT + 50);
      check("midreset_no_event", 32'(ev_cnt), 32'(ev0));
      send_frame(8'h1C, 1'b0);
      check("after_reset_kc", keyb_char, 32'h0000001C);
      check("after_reset_byte", {24'd0, rx_byte}, 32'h0000001C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- PS/2 keyboard receiver; sits directly upstream of the memory-mapped IO block and drives its 32-bit `keyb_char` input.
- Synchronizes and filters the raw PS/2 clock/data pins and deframes 11-bit frames into scancode bytes.
- Tracks E0 (extended) and F0 (break) prefixes, so `keyb_char` holds the currently pressed key and returns to 0 when that key is released.
- The CPU polls the key state with a load from the keyboard address.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized samples required before the filtered ps2_clk/ps2_data change.
- TIMEOUT_CYCLES, 100000: clk cycles with no filtered falling edge mid-frame before the frame is abandoned (1 ms at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high reset
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous, idle high
- ps2_data  in  1  raw PS/2 data pin, asynchronous, idle high
- keyb_char  out  32  {23'b0, ext, code[7:0]} of the held key; 0 when no key is held
- rx_byte  out  8  last correctly received byte
- rx_valid  out  1  one-cycle pulse when rx_byte updates
- rx_err  out  1  one-cycle pulse on parity, framing or timeout error

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: keyb_char=0, rx_byte=0, rx_valid=0, rx_err=0. Sync flops and filtered clk/data =1. FSM=IDLE. Prefix flags=0. Counters=0.
- Input conditioning:
  - Each pin goes through a 2-flop synchronizer.
  - The filtered value flips only after FILTER_LEN consecutive synchronized samples differ from it.
  - Falling edge = filtered clk was 1 last cycle and is 0 this cycle.
  - All data sampling happens on filtered falling edges, using filtered data.
- Frame FSM (states IDLE, DATA, PARITY, STOP):
  - IDLE: on an edge, data=0 (start bit) -> DATA with bitcnt=0; data=1 -> stay in IDLE, no error.
  - DATA: on an edge, shift the data bit in LSB-first at position bitcnt. bitcnt=7 -> PARITY, otherwise bitcnt+1.
  - PARITY: on an edge, store the parity bit -> STOP.
  - STOP: on an edge, data=1 and parity good -> frame OK. Otherwise -> error. Either way -> IDLE.
  - Parity is good when the XOR of the 8 data bits and the parity bit equals 1 (odd parity).
  - Timeout: in any state except IDLE, a counter is cleared on each edge. When it reaches TIMEOUT_CYCLES-1: rx_err pulse, go to IDLE, discard the partial byte.
- Output latency and error behaviour:
  - Stop edge detected in cycle N -> rx_valid (or rx_err) high during cycle N+1.
  - rx_byte is valid from cycle N+1.
  - keyb_char is updated at the edge ending cycle N+1, so it is visible from cycle N+2.
  - Errored frames change neither rx_byte nor keyb_char.
- Scancode decoder (acts on each rx_valid):
  - byte=E0: ext_pend<=1.
  - byte=F0: brk_pend<=1.
  - other byte, brk_pend=1: if {ext_pend,byte}==keyb_char[8:0], keyb_char<=0, else keyb_char unchanged. Clear both flags.
  - other byte, brk_pend=0: keyb_char<={23'b0,ext_pend,byte}; ext_pend<=0.
- Boundary conditions:
  - Release of a key that is not the current key is ignored. A new make overwrites the held key (last-pressed wins).
  - An rx_err does not clear the prefix flags.
  - Reset asserted mid-frame aborts the frame immediately, with no rx_err pulse.
  - Host-to-device transmission is not supported; the pins are input-only.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: the parity check is applied as above; a bad-parity frame gives an rx_err pulse and is dropped.
- Undefined: the parity bit is sampled and ignored; only a bad stop bit or a timeout produces rx_err.

Decomposition:
- Package ps2_pkg holds:
  - enum rx_state_t {IDLE, DATA, PARITY, STOP};
  - localparams PS2_EXT_CODE=8'hE0, PS2_BREAK_CODE=8'hF0;
  - keyb_char field widths.
- Sub-module ps2_rx_frame: synchronizers, filter, edge detect, frame FSM, timeout. Outputs rx_byte/rx_valid/rx_err.
- ps2_keyboard instantiates ps2_rx_frame and holds the prefix flags and the keyb_char register.

Test Plan:
- Drive PS/2 frames at a 12.5 kHz device clock (bit period 80 us = 8000 clk cycles).
- Key "A": send frame 0x1C (parity bit 0) -> rx_valid pulse, rx_byte=0x1C, keyb_char=0x0000001C. Then send F0, 1C -> keyb_char=0.
- Extended key: send E0, 75 -> keyb_char=0x00000175. Then send E0, F0, 75 -> keyb_char=0.
- Bad parity: send 0x1C with parity bit 1 -> rx_err pulse, no rx_valid, keyb_char unchanged. Repeat without PS2_PARITY_CHECK_EN -> rx_valid, rx_byte=0x1C.
- Timeout: stop the device clock after 4 data bits -> rx_err exactly TIMEOUT_CYCLES cycles after the last edge. A following full 0x29 frame -> keyb_char=0x29.
- Glitches: put 3-cycle low pulses on ps2_clk while idle (with FILTER_LEN=8) -> no edge, no rx_valid, no rx_err, FSM stays in IDLE.
- Overlap and reset: press 1C, press 32 -> keyb_char=0x32. F0,1C -> still 0x32. Assert reset mid-frame -> all outputs 0 and the next frame decodes correctly.
